// File: rtl/recip_coef_streamer_pkg.sv
// Shared definitions for the reciprocal coefficient streamer.
//   RECIP_FRAC_DEFAULT : default number of fractional bits (1.0 = 2^FRAC)
//   recip_entry()      : saturated fixed-point value of 1/(n+1), evaluated at elaboration
//   state_t            : sequencing states of the streamer
package recip_pkg;

    localparam int RECIP_FRAC_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // floor(2^frac / (n+1)), clipped to 2^frac - 1 so entry 0 still fits in frac bits.
    function automatic int recip_entry(input int n, input int frac, input int dw);
        int one;
        int v;
        one = 1 << frac;
        v   = one / (n + 1);
        if (v > one - 1)
            v = one - 1;
        if (dw < 31)
            v = v & ((1 << dw) - 1);
        return v;
    endfunction

endpackage

// File: rtl/recip_coef_streamer_if.sv
// Request/output handshake bundle for recip_coef_streamer.
//   req_valid/req_ready        : request handshake from the iteration controller
//   req_addr/req_burst/req_len : start index, burst select, burst entry count
//   out_valid/out_ready        : beat handshake toward the multiply-accumulate unit
//   out_data/out_idx/out_last/out_err : beat payload
//   busy                       : a burst is in progress
// master = requester/consumer side, slave = streamer side.
interface recip_coef_streamer_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_burst;
    logic [AW-1:0] req_len;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          out_err;
    logic          busy;

    modport master (
        output req_valid, req_addr, req_burst, req_len, out_ready,
        input  req_ready, out_valid, out_data, out_idx, out_last, out_err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_burst, req_len, out_ready,
        output req_ready, out_valid, out_data, out_idx, out_last, out_err, busy
    );
endinterface

// File: rtl/recip_coef_streamer_lut.sv
// Combinational reciprocal table, DEPTH entries generated from recip_entry().
//   addr     : table index (may exceed DEPTH-1)
//   data     : entry[addr], or 0 when addr is out of range
//   in_range : addr < DEPTH
module recip_lut
    import recip_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int DW    = 16,
    parameter int FRAC  = RECIP_FRAC_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          in_range
);
    logic [DW-1:0] tbl [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        assign tbl[i] = DW'(recip_entry(i, FRAC, DW));
    end

    always_comb begin
        in_range = (int'(addr) < DEPTH);
        data     = '0;
        if (in_range)
            data = tbl[addr];
    end
endmodule

// File: rtl/recip_coef_streamer.sv
// Streams reciprocal coefficients 1/(n+1) as single lookups or wrapping bursts,
// through a single registered output slot with valid/ready backpressure.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : request and output handshake (slave side), plus busy
module recip_coef_streamer
    import recip_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int DW    = 16,
    parameter int FRAC  = RECIP_FRAC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    recip_coef_streamer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state, state_nx;
    logic [AW-1:0] rem_q, rem_nx;
    logic          valid_q, valid_nx;
    logic [DW-1:0] data_q, data_nx;
    logic [AW-1:0] idx_q, idx_nx;
    logic          last_q, last_nx;
    logic          err_q, err_nx;
    logic          load;

    logic          slot_free;
    logic          accept;
    logic [AW-1:0] next_idx;
    logic [AW-1:0] eff_len;
    logic [AW-1:0] lut_addr;
    logic [DW-1:0] lut_data;
    logic          lut_ok;

    assign slot_free     = !valid_q || bus.out_ready;
    assign bus.req_ready = (state == IDLE) && slot_free && rst_n;
    assign accept        = bus.req_valid && bus.req_ready;
    assign next_idx      = (idx_q == LAST_IDX) ? '0 : idx_q + AW'(1);
    assign eff_len       = !bus.req_burst       ? AW'(1) :
                           (bus.req_len == '0)  ? AW'(1) : bus.req_len;
    // One table port serves both the first beat and the following burst beats.
    assign lut_addr      = (state == STREAM) ? next_idx : bus.req_addr;

    recip_lut #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .FRAC  (FRAC),
        .AW    (AW)
    ) u_lut (
        .addr     (lut_addr),
        .data     (lut_data),
        .in_range (lut_ok)
    );

    always_comb begin
        state_nx = state;
        rem_nx   = rem_q;
        load     = 1'b0;
        data_nx  = data_q;
        idx_nx   = idx_q;
        last_nx  = last_q;
        err_nx   = err_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    data_nx = lut_data;
                    idx_nx  = bus.req_addr;
                    err_nx  = !lut_ok;
                    // An out-of-range start yields exactly one error beat, bursts included.
                    if (!lut_ok || eff_len == AW'(1)) begin
                        last_nx = 1'b1;
                        rem_nx  = '0;
                    end else begin
                        last_nx  = 1'b0;
                        rem_nx   = eff_len - AW'(1);
                        state_nx = STREAM;
                    end
                end
            end
            STREAM: begin
                if (slot_free) begin
                    load    = 1'b1;
                    data_nx = lut_data;
                    idx_nx  = next_idx;
                    err_nx  = 1'b0;
                    rem_nx  = rem_q - AW'(1);
                    last_nx = (rem_q == AW'(1));
                    if (rem_q == AW'(1))
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        valid_nx = valid_q;
        if (load)
            valid_nx = 1'b1;
        else if (bus.out_ready)
            valid_nx = 1'b0;
    end

    // Output slot and sequencing state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            rem_q   <= rem_nx;
            valid_q <= valid_nx;
            if (load) begin
                data_q <= data_nx;
                idx_q  <= idx_nx;
                last_q <= last_nx;
                err_q  <= err_nx;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = (state == STREAM);
endmodule

// File: tb/tb_recip_coef_streamer.sv
// Directed self-checking bench for recip_coef_streamer (DEPTH=12, DW=16, FRAC=8).
module tb_recip_coef_streamer;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    recip_coef_streamer_if #(.DW(16), .AW(4)) bus ();

    recip_coef_streamer #(
        .DEPTH (12),
        .DW    (16),
        .FRAC  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b_data [4];
        int b_idx  [4];
        int b_last [4];
        int b_busy [4];
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_burst = 1'b0;
        bus.req_len   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_data", bus.out_data, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1);

        // Single lookup addr=2
        bus.out_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd2;
        bus.req_burst = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk("s2_valid", bus.out_valid, 1);
        chk("s2_data", bus.out_data, 85);
        chk("s2_idx", bus.out_idx, 2);
        chk("s2_last", bus.out_last, 1);
        chk("s2_err", bus.out_err, 0);
        tick();
        chk("s2_drain", bus.out_valid, 0);

        // Wrapping burst addr=10 len=4
        b_data = '{23, 21, 255, 128};
        b_idx  = '{10, 11, 0, 1};
        b_last = '{0, 0, 0, 1};
        b_busy = '{1, 1, 1, 0};
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd10;
        bus.req_burst = 1'b1;
        bus.req_len   = 4'd4;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b10_valid%0d", i), bus.out_valid, 1);
            chk($sformatf("b10_data%0d", i), bus.out_data, b_data[i]);
            chk($sformatf("b10_idx%0d", i), bus.out_idx, b_idx[i]);
            chk($sformatf("b10_last%0d", i), bus.out_last, b_last[i]);
            chk($sformatf("b10_busy%0d", i), bus.busy, b_busy[i]);
            tick();
        end
        chk("b10_drain", bus.out_valid, 0);

        // Burst addr=0 len=3 with backpressure
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd0;
        bus.req_len   = 4'd3;
        tick();
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_data0", bus.out_data, 255);
        chk("bp_req_ready0", bus.req_ready, 0);
        tick();
        bus.out_ready = 1'b0;
        chk("bp_data1", bus.out_data, 128);
        chk("bp_idx1", bus.out_idx, 1);
        tick();
        chk("bp_hold1_valid", bus.out_valid, 1);
        chk("bp_hold1_data", bus.out_data, 128);
        chk("bp_hold1_req_ready", bus.req_ready, 0);
        tick();
        chk("bp_hold2_data", bus.out_data, 128);
        chk("bp_hold2_last", bus.out_last, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_data2", bus.out_data, 85);
        chk("bp_last2", bus.out_last, 1);
        bus.out_ready = 1'b0;
        #1;
        chk("bp_last_stall_req_ready", bus.req_ready, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_last_consume_req_ready", bus.req_ready, 1);
        tick();
        chk("bp_drain", bus.out_valid, 0);

        // Out-of-range single and burst
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd13;
        bus.req_burst = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk("oor13_err", bus.out_err, 1);
        chk("oor13_data", bus.out_data, 0);
        chk("oor13_idx", bus.out_idx, 13);
        chk("oor13_last", bus.out_last, 1);
        tick();
        chk("oor13_drain", bus.out_valid, 0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd15;
        bus.req_burst = 1'b1;
        bus.req_len   = 4'd5;
        tick();
        bus.req_valid = 1'b0;
        chk("oor15_valid", bus.out_valid, 1);
        chk("oor15_err", bus.out_err, 1);
        chk("oor15_last", bus.out_last, 1);
        chk("oor15_busy", bus.busy, 0);
        tick();
        chk("oor15_drain", bus.out_valid, 0);
        chk("oor15_busy_after", bus.busy, 0);
        tick();
        chk("oor15_no_extra", bus.out_valid, 0);

        // Reset mid-burst
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd3;
        bus.req_burst = 1'b1;
        bus.req_len   = 4'd6;
        tick();
        bus.req_valid = 1'b0;
        chk("mr_data0", bus.out_data, 64);
        tick();
        chk("mr_data1", bus.out_data, 51);
        chk("mr_busy1", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid_in_rst", bus.out_valid, 0);
        chk("mr_busy_in_rst", bus.busy, 0);
        chk("mr_req_ready_in_rst", bus.req_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_no_resume", bus.out_valid, 0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd7;
        bus.req_burst = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk("mr_s7_data", bus.out_data, 32);
        chk("mr_s7_idx", bus.out_idx, 7);
        tick();
        chk("mr_s7_drain", bus.out_valid, 0);

        // Back-to-back: burst addr=11 len=2, then len=0 burst at addr=4
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd11;
        bus.req_burst = 1'b1;
        bus.req_len   = 4'd2;
        tick();
        bus.req_valid = 1'b0;
        chk("bb_data0", bus.out_data, 21);
        tick();
        chk("bb_data1", bus.out_data, 255);
        chk("bb_idx1", bus.out_idx, 0);
        chk("bb_last1", bus.out_last, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd4;
        bus.req_burst = 1'b1;
        bus.req_len   = 4'd0;
        #1;
        chk("bb_req_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        chk("bb_next_valid", bus.out_valid, 1);
        chk("bb_next_data", bus.out_data, 51);
        chk("bb_next_idx", bus.out_idx, 4);
        chk("bb_next_last", bus.out_last, 1);
        chk("bb_next_busy", bus.busy, 0);
        tick();
        chk("bb_len0_one_beat", bus.out_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/recip_coef_streamer.md
Name: recip_coef_streamer

Overview:
- Parametrised successor to the fixed 12-entry reciprocal coefficient ROM.
- Serves unsigned fixed-point reciprocals 1/(n+1) with FRAC fractional bits to the series-expansion datapath.
- Supports single lookups and multi-entry bursts, with a registered output and valid/ready backpressure.
- Sits between the iteration controller (request side) and the multiply-accumulate unit (output side).

Parameters:
- DEPTH, 12, number of table entries; index n in 0..DEPTH-1.
- DW, 16, output data width.
- FRAC, 8, fractional bits; 1.0 is 2^FRAC. Constraint: FRAC < DW.
- AW, $clog2(DEPTH), address and length width; derived, not overridden.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_addr  in  AW  start index n.
- req_burst  in  1  0 = single lookup; 1 = burst of req_len entries.
- req_len  in  AW  burst entry count; 0 is treated as 1; ignored when req_burst=0.
- out_valid  out  1  out_data, out_idx, out_last and out_err are valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DW  coefficient for index out_idx.
- out_idx  out  AW  index of the current beat.
- out_last  out  1  final beat of the request.
- out_err  out  1  start index was out of range; out_data = 0.
- busy  out  1  a burst is in progress (state STREAM).

Behaviour:
- Table contents:
  - entry[n] = min(floor(2^FRAC/(n+1)), 2^FRAC-1), zero-extended to DW.
  - Entries are computed at elaboration, not hand-listed.
  - Defaults give 255,128,85,64,51,42,36,32,28,25,23,21.
- Reset:
  - Asynchronous on rst_n low: state=IDLE; out_valid, out_data, out_idx, out_last, out_err, busy all 0.
  - req_ready is forced 0 while rst_n is low.
  - Reset mid-burst aborts the burst; no further beats are issued.
- Output register:
  - Single slot. A beat holds all output fields stable while out_valid && !out_ready.
  - slot_free = !out_valid || out_ready.
- req_ready = (state==IDLE) && slot_free && rst_n.
- States:
  - IDLE: accepting requests.
  - STREAM: burst active; busy=1; req_ready=0.
- Accept in IDLE (handshake on edge k):
  - The first beat is visible from edge k, i.e. out_valid=1 in cycle k+1. Latency is 1 cycle.
  - Single lookup: out_idx=req_addr, out_last=1; stay in IDLE.
  - Burst with effective length L: first beat out_idx=req_addr; internal remaining = L-1.
  - If L=1: out_last=1, stay in IDLE. Otherwise out_last=0, go to STREAM.
- STREAM:
  - On each edge where slot_free, load the next beat with idx = (idx+1) mod DEPTH and decrement remaining.
  - Indices wrap from DEPTH-1 to 0 with no error.
  - When remaining reaches 0 on a load, that beat has out_last=1 and the state returns to IDLE in the same edge.
  - Sustained throughput is 1 beat per cycle while out_ready=1; there are no bubbles between beats.
- Beat drain: if out_valid && out_ready with no new beat loaded, out_valid goes to 0 at the edge.
- Out-of-range start (req_addr >= DEPTH):
  - Exactly one beat: out_err=1, out_data=0, out_idx=req_addr, out_last=1.
  - A requested burst is cancelled; the state stays IDLE.
- Back-to-back:
  - A new request may be accepted in the same cycle the last beat of the previous request is consumed (IDLE && out_ready).
  - Its first beat replaces the old one at that edge.
- Simultaneous events: req_valid is ignored during STREAM; out_ready has no effect when out_valid=0.
- Arithmetic: entry computation is elaboration-time integer division only; no runtime divider.

Decomposition:
- Shared package recip_pkg:
  - constant RECIP_FRAC_DEFAULT.
  - function recip_entry(n, frac, dw) returning the saturated value.
  - enum state_t {IDLE, STREAM}.
- Sub-module recip_lut:
  - Purely combinational DEPTH-entry table, generated with recip_entry.
  - Outputs data and an in_range flag.
  - Instantiated once; the streamer owns all sequencing and the output register.

Test Plan:
- Reset, then single lookup addr=2 with out_ready=1 -> one cycle later out_data=85, out_idx=2, out_last=1, out_err=0; out_valid drops next cycle.
- Burst addr=10, len=4, out_ready=1 -> 4 consecutive beats with out_data 23,21,255,128, out_idx 10,11,0,1; out_last only on the 4th; busy high during beats 1-3.
- Burst addr=0, len=3, out_ready toggling 1,0,0,1,1 -> beats 255,128,85 in order; beat held stable across the stalls; no loss or duplication; req_ready=0 until the last beat is consumed.
- Single lookup addr=13 (DEPTH=12) -> out_err=1, out_data=0, out_last=1; burst addr=15 len=5 -> exactly one error beat, state stays IDLE.
- rst_n pulled low mid-burst (after beat 2 of len=6) -> out_valid=0 and busy=0 immediately; after release, a single lookup addr=7 returns 32.
- Back-to-back: last beat consumed while the next req_valid is high (addr=4) -> accepted that cycle; the following beat is 51 with no idle cycle; len=0 burst yields 1 beat.
